// File: rtl/neureka_tcdm_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neureka_tcdm_responder_pkg
// Description : Shared constants and response type for the Neureka TCDM
//               responder (weight-memory port slave).
// Revision    : 1.0 - initial release
// ============================================================================
package neureka_tcdm_responder_pkg;

    // External memory bandwidth of the streamer, in bits (36 bytes)
    localparam int NEUREKA_MEM_BANDWIDTH_EXT = 288;

    // Depth of the on-cluster weight memory, in bandwidth-wide words
    localparam int NEUREKA_WMEM_NB_WORDS     = 256;

    // One response beat: read data (zero for writes) plus out-of-range flag
    typedef struct packed {
        logic [NEUREKA_MEM_BANDWIDTH_EXT-1:0] data;
        logic                                 opc;
    } resp_t;

endpackage : neureka_tcdm_responder_pkg
`default_nettype wire

// File: rtl/neureka_tcdm_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : neureka_tcdm_resp_fifo
// Description : Synchronous FIFO of resp_t with push, pop, occupancy count
//               and a synchronous flush. The responder's credit scheme
//               guarantees a push never arrives while full.
// Revision    : 1.0 - initial release
// ============================================================================
module neureka_tcdm_resp_fifo
    import neureka_tcdm_responder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_clear,
    input  logic          i_push,
    input  resp_t         i_data,
    input  logic          i_pop,
    output resp_t         o_data,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_t           r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_pop;

    // Pointer advance with wrap for non-power-of-two depths
    function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
    endfunction

    assign w_pop   = i_pop & (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage: contents need no reset, validity is tracked by the count
    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers and occupancy; flush takes priority over push/pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= f_inc(r_wptr);
            if (w_pop)  r_rptr <= f_inc(r_rptr);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : neureka_tcdm_resp_fifo
`default_nettype wire

// File: rtl/neureka_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module      : neureka_tcdm_responder
// Description : HCI TCDM slave backing the Neureka weight-memory port with a
//               local word-addressed array. Grants under credit control and
//               returns one in-order response per granted transaction after
//               LATENCY pipeline stages plus the response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module neureka_tcdm_responder
    import neureka_tcdm_responder_pkg::*;
#(
    parameter int DW              = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int AW              = 32,
    parameter int NB_WORDS        = NEUREKA_WMEM_NB_WORDS,
    parameter int LATENCY         = 1,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            enable_i,
    input  logic            tcdm_req_i,
    output logic            tcdm_gnt_o,
    input  logic [AW-1:0]   tcdm_add_i,
    input  logic            tcdm_wen_i,
    input  logic [DW/8-1:0] tcdm_be_i,
    input  logic [DW-1:0]   tcdm_data_i,
    output logic            tcdm_r_valid_o,
    input  logic            tcdm_r_ready_i,
    output logic [DW-1:0]   tcdm_r_data_o,
    output logic            tcdm_r_opc_o,
    output logic            busy_o,
    output logic            err_o
);

    localparam int c_BW  = DW / 8;
    localparam int c_OFS = $clog2(c_BW);
    localparam int c_IW  = $clog2(NB_WORDS);
    localparam int c_FCW = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int c_ICW = $clog2(RESP_FIFO_DEPTH + LATENCY + 1);
    localparam int c_RW  = NEUREKA_MEM_BANDWIDTH_EXT;

    logic [DW-1:0]      r_mem [NB_WORDS];
    logic [LATENCY-1:0] r_pipe_vld;
    resp_t              r_pipe_resp [LATENCY];
    logic               r_err;

    logic [AW-1:0]      w_word_addr;
    logic               w_in_range;
    logic [c_IW-1:0]    w_idx;
    logic               w_hs;
    logic [DW-1:0]      w_rd_data;
    resp_t              w_resp_in;
    resp_t              w_fifo_out;
    logic               w_fifo_empty;
    logic               w_pop;
    logic [c_FCW-1:0]   w_fifo_count;
    logic [c_ICW-1:0]   w_inflight;
    logic               w_credit;

    // Address decode: the full word address must fit in the array
    assign w_word_addr = tcdm_add_i >> c_OFS;
    assign w_in_range  = (w_word_addr < AW'(NB_WORDS));
    assign w_idx       = tcdm_add_i[c_OFS +: c_IW];

    // Credit: every in-flight transaction owns a FIFO slot
    always_comb begin
        w_inflight = c_ICW'(w_fifo_count);
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + c_ICW'(r_pipe_vld[i]);
        end
    end

    assign w_credit   = (w_inflight < c_ICW'(RESP_FIFO_DEPTH));
    assign tcdm_gnt_o = tcdm_req_i & enable_i & ~clear_i & w_credit;
    assign w_hs       = tcdm_gnt_o;

    // Response payload captured at the grant edge
    assign w_rd_data      = (w_in_range && tcdm_wen_i) ? r_mem[w_idx] : '0;
    assign w_resp_in.data = c_RW'(w_rd_data);
    assign w_resp_in.opc  = ~w_in_range;

    // Array write with byte enables; out-of-range writes are dropped
    always_ff @(posedge clk_i) begin
        if (w_hs && !tcdm_wen_i && w_in_range) begin
            for (int b = 0; b < c_BW; b++) begin
                if (tcdm_be_i[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= tcdm_data_i[b*8 +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 holds the grant-edge sample, the last stage pushes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe_resp[i] <= '0;
            end
        end else if (clear_i) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0]  <= w_hs;
            r_pipe_resp[0] <= w_resp_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_resp[i] <= r_pipe_resp[i-1];
            end
        end
    end

    // Sticky out-of-range flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (clear_i) begin
            r_err <= 1'b0;
        end else if (w_hs && !w_in_range) begin
            r_err <= 1'b1;
        end
    end

    assign w_pop = ~w_fifo_empty & tcdm_r_ready_i;

    neureka_tcdm_resp_fifo #(
        .DEPTH   (RESP_FIFO_DEPTH),
        .CW      (c_FCW)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (clear_i),
        .i_push  (r_pipe_vld[LATENCY-1]),
        .i_data  (r_pipe_resp[LATENCY-1]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Outputs are forced to zero when no response is presented
    assign tcdm_r_valid_o = ~w_fifo_empty;
    assign tcdm_r_data_o  = w_fifo_empty ? '0 : DW'(w_fifo_out.data);
    assign tcdm_r_opc_o   = ~w_fifo_empty & w_fifo_out.opc;
    assign busy_o         = (w_inflight != '0);
    assign err_o          = r_err;

endmodule : neureka_tcdm_responder
`default_nettype wire

// File: tb/tb_neureka_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_neureka_tcdm_responder
// Description : Self-checking bench for neureka_tcdm_responder. Expected
//               responses are queued at grant time; a monitor pops and
//               compares on every accepted response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neureka_tcdm_responder;

    typedef struct packed {
        logic [287:0] d;
        logic         opc;
    } exp_t;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         clear   = 1'b0;
    logic         enable  = 1'b1;
    logic         req     = 1'b0;
    logic [31:0]  add     = '0;
    logic         wen     = 1'b1;
    logic [35:0]  be      = '0;
    logic [287:0] wdata   = '0;
    logic         r_ready = 1'b1;
    logic         gnt;
    logic         r_valid;
    logic [287:0] r_data;
    logic         r_opc;
    logic         busy;
    logic         err;

    exp_t         sb [$];
    exp_t         m_e;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           grants;
    logic [7:0]   bt;

    localparam logic [35:0]  BE_ALL = '1;
    localparam logic [287:0] PAT_A5 = {36{8'hA5}};

    neureka_tcdm_responder dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .enable_i       (enable),
        .tcdm_req_i     (req),
        .tcdm_gnt_o     (gnt),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_be_i      (be),
        .tcdm_data_i    (wdata),
        .tcdm_r_valid_o (r_valid),
        .tcdm_r_ready_i (r_ready),
        .tcdm_r_data_o  (r_data),
        .tcdm_r_opc_o   (r_opc),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wa(input int w);
        return 32'(w) << 6;
    endfunction

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Issue one transaction, wait (bounded) for grant, queue its expected response
    task automatic do_req(input logic [31:0] a, input logic w, input logic [35:0] b,
                          input logic [287:0] d, input logic [287:0] ed, input logic eo);
        int   n;
        exp_t e;
        req = 1'b1; add = a; wen = w; be = b; wdata = d; n = 0;
        @(negedge clk);
        while (!gnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!gnt) begin
            n_fail++;
            $display("FAIL gnt_timeout: got no grant after %0d cycles, required a grant", n);
        end else begin
            e.d = ed; e.opc = eo;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", sb.size());
        end
    endtask

    // Single read from an idle responder: r_valid low at grant+1, high at grant+2
    task automatic lat_read(input logic [31:0] a, input logic [287:0] ed, input string tag);
        do_req(a, 1'b1, '0, '0, ed, 1'b0);
        @(negedge clk);
        check({tag, "_valid_g1"}, 288'(r_valid), 288'(1'b0));
        check({tag, "_busy_g1"},  288'(busy),    288'(1'b1));
        @(negedge clk);
        check({tag, "_valid_g2"}, 288'(r_valid), 288'(1'b1));
    endtask

    // Scoreboard monitor: compare every accepted response in order
    always @(negedge clk) begin
        if (rst_n && r_valid && r_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got data %h with no response pending", r_data);
            end else begin
                m_e = sb.pop_front();
                check("resp_data", r_data,        m_e.d);
                check("resp_opc",  288'(r_opc),   288'(m_e.opc));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",    288'(gnt),     '0);
        check("rst_rvalid", 288'(r_valid), '0);
        check("rst_rdata",  r_data,        '0);
        check("rst_ropc",   288'(r_opc),   '0);
        check("rst_busy",   288'(busy),    '0);
        check("rst_err",    288'(err),     '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full write then read-after-write of the same word
        do_req(wa(3), 1'b0, BE_ALL, PAT_A5, '0, 1'b0);
        do_req(wa(3), 1'b1, '0, '0, PAT_A5, 1'b0);
        wait_drain();
        lat_read(wa(3), PAT_A5, "lat");
        wait_drain();

        // Partial write: only byte 0 may change
        do_req(wa(5), 1'b0, BE_ALL, '0, '0, 1'b0);
        do_req(wa(5), 1'b0, 36'h1, {{35{8'h77}}, 8'hFF}, '0, 1'b0);
        do_req(wa(5), 1'b1, '0, '0, {280'h0, 8'hFF}, 1'b0);
        wait_drain();

        // Distinct words for ordering checks
        for (int k = 0; k < 4; k++) begin
            bt = 8'h10 + 8'(k);
            do_req(wa(10 + k), 1'b0, BE_ALL, {36{bt}}, '0, 1'b0);
        end
        wait_drain();

        // Back-pressure: exactly RESP_FIFO_DEPTH grants while r_ready is low
        r_ready = 1'b0;
        req = 1'b1; wen = 1'b1; grants = 0;
        for (int c = 0; c < 12; c++) begin
            add = (grants < 4) ? wa(10 + grants) : wa(10);
            @(negedge clk);
            if (gnt) begin
                bt = 8'h10 + 8'(grants);
                m_e.d = {36{bt}}; m_e.opc = 1'b0;
                sb.push_back(m_e);
                grants++;
            end
            @(posedge clk); #1;
        end
        check("bp_grants", 288'(grants), 288'(4));
        @(negedge clk);
        check("bp_gnt_low", 288'(gnt),  '0);
        check("bp_busy",    288'(busy), 288'(1'b1));
        @(posedge clk); #1;
        req = 1'b0;
        r_ready = 1'b1;
        wait_drain();
        do_req(wa(13), 1'b1, '0, '0, {36{8'h13}}, 1'b0);
        wait_drain();

        // Out-of-range read and write; the write must not alias word 3
        do_req(wa(256), 1'b1, '0, '0, '0, 1'b1);
        wait_drain();
        check("oor_err_set", 288'(err), 288'(1'b1));
        do_req(wa(259), 1'b0, BE_ALL, {36{8'hFF}}, '0, 1'b1);
        do_req(wa(3), 1'b1, '0, '0, PAT_A5, 1'b0);
        wait_drain();
        check("oor_err_sticky", 288'(err), 288'(1'b1));
        clear = 1'b1; req = 1'b1; wen = 1'b1; add = wa(3);
        @(negedge clk);
        check("clr_gnt", 288'(gnt), '0);
        @(posedge clk); #1;
        clear = 1'b0; req = 1'b0;
        check("clr_err", 288'(err), '0);

        // Clear with responses pending
        r_ready = 1'b0;
        do_req(wa(10), 1'b1, '0, '0, {36{8'h10}}, 1'b0);
        do_req(wa(11), 1'b1, '0, '0, {36{8'h11}}, 1'b0);
        do_req(wa(12), 1'b1, '0, '0, {36{8'h12}}, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        sb.delete();
        check("clrp_rvalid", 288'(r_valid), '0);
        check("clrp_busy",   288'(busy),    '0);
        r_ready = 1'b1;
        do_req(wa(10), 1'b1, '0, '0, {36{8'h10}}, 1'b0);
        do_req(wa(5),  1'b1, '0, '0, {280'h0, 8'hFF}, 1'b0);
        wait_drain();

        // Enable low blocks grants
        enable = 1'b0; req = 1'b1; wen = 1'b1; add = wa(3);
        @(negedge clk);
        check("en_gnt_low", 288'(gnt), '0);
        @(posedge clk); #1;
        enable = 1'b1;
        do_req(wa(3), 1'b1, '0, '0, PAT_A5, 1'b0);
        wait_drain();

        // Asynchronous reset in the middle of a burst
        do_req(wa(300), 1'b1, '0, '0, '0, 1'b1);
        wait_drain();
        r_ready = 1'b0;
        do_req(wa(3), 1'b1, '0, '0, PAT_A5, 1'b0);
        do_req(wa(5), 1'b1, '0, '0, {280'h0, 8'hFF}, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rvalid", 288'(r_valid), '0);
        check("arst_rdata",  r_data,        '0);
        check("arst_ropc",   288'(r_opc),   '0);
        check("arst_busy",   288'(busy),    '0);
        check("arst_err",    288'(err),     '0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        r_ready = 1'b1;
        @(posedge clk); #1;
        lat_read(wa(3), PAT_A5, "arst_lat");
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_neureka_tcdm_responder
`default_nettype wire
